// File: rtl/pc_seq_unit.sv
// Program-counter sequencer for the single-cycle core.
// Holds the PC and computes the next PC. Supports stall hold, a circular
// return-address stack (RAS), exception entry and ERET via EPC.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   pc_wr    - 1 advances the PC; 0 stalls (all state holds)
//   pc_src   - 0 PLUS4, 1 BRANCH, 2 JUMP, 3 JR, 4 RET, 5 ERET, 6/7 act as PLUS4
//   zero     - branch taken when 1
//   br_off   - signed word offset for BRANCH
//   j_imm    - word index for JUMP
//   jr_tgt   - register target for JR
//   link     - with JUMP/JR and pc_wr, push pc+4 onto the RAS
//   exc      - exception request (taken even while stalled)
//   pc       - current PC
//   epc      - PC of the instruction at the last exception
//   ras_cnt  - number of valid RAS entries, 0..RAS_DEPTH
//   ras_ovf  - sticky: push while full
//   ras_unf  - sticky: RET while empty
module pc_seq_unit #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    RESET_VEC = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0]    EXC_VEC   = ADDR_W'(32'h0000_4180),
  parameter int unsigned          RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pc_wr,
  input  logic [2:0]                   pc_src,
  input  logic                         zero,
  input  logic [15:0]                  br_off,
  input  logic [25:0]                  j_imm,
  input  logic [ADDR_W-1:0]            jr_tgt,
  input  logic                         link,
  input  logic                         exc,
  output logic [ADDR_W-1:0]            pc,
  output logic [ADDR_W-1:0]            epc,
  output logic [$clog2(RAS_DEPTH):0]   ras_cnt,
  output logic                         ras_ovf,
  output logic                         ras_unf
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(RAS_DEPTH);

  localparam logic [2:0] SrcPlus4  = 3'd0;
  localparam logic [2:0] SrcBranch = 3'd1;
  localparam logic [2:0] SrcJump   = 3'd2;
  localparam logic [2:0] SrcJr     = 3'd3;
  localparam logic [2:0] SrcRet    = 3'd4;
  localparam logic [2:0] SrcEret   = 3'd5;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [PtrW-1:0]   top_q, top_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push;

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  logic [ADDR_W-1:0] p4;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] jr_word;
  logic              unused_jr_lsb;

  assign p4     = pc_q + ADDR_W'(4);
  assign br_tgt = p4 + {{(ADDR_W-18){br_off[15]}}, br_off, 2'b00};
  assign jr_word = {jr_tgt[ADDR_W-1:2], 2'b00};
  assign unused_jr_lsb = ^jr_tgt[1:0];

  // Upper PC bits come from p4; the low 28 bits are replaced by the jump index.
  always_comb begin
    jump_tgt       = p4;
    jump_tgt[27:0] = {j_imm, 2'b00};
  end

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (exc) begin
      epc_d = pc_q;
      pc_d  = EXC_VEC;
    end else if (pc_wr) begin
      case (pc_src)
        SrcBranch: pc_d = zero ? br_tgt : p4;
        SrcJump: begin
          pc_d = jump_tgt;
          push = link;
        end
        SrcJr: begin
          pc_d = jr_word;
          push = link;
        end
        SrcRet: begin
          if (cnt_q != '0) begin
            pc_d  = ras_q[top_q];
            top_d = top_q - PtrW'(1);
            cnt_d = cnt_q - CntW'(1);
          end else begin
            pc_d  = p4;
            unf_d = 1'b1;
          end
        end
        SrcEret: pc_d = epc_q;
        default: pc_d = p4;
      endcase
      // Top pointer wraps, so a push when full overwrites the oldest entry.
      if (push) begin
        top_d = top_q + PtrW'(1);
        if (cnt_q == CntFull) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      epc_q <= '0;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry storage needs no reset; ras_cnt gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      ras_q[top_d] <= p4;
    end
  end

  assign pc      = pc_q;
  assign epc     = epc_q;
  assign ras_cnt = cnt_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule
